pstats_cnt_bank: RTL and testbench

PSTATS_CNT_BANK -- requirements
Module: pstats_cnt_bank

---
 rtl/pstats_pkg.sv | 13 +
 rtl/pstats_counter.sv | 38 +++
 rtl/pstats_cnt_bank.sv | 94 +++++++++
 tb/tb_pstats_cnt_bank.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pstats_pkg.sv
// pstats_pkg: address map, control bit positions and counter indexing for the stats bank
package pstats_pkg;
  localparam logic [15:0] ADR_CR   = 16'h0000;
  localparam logic [15:0] ADR_INFO = 16'h0001;
  localparam logic [15:0] ADR_OVF  = 16'h0002;
  localparam logic [15:0] ADR_CNT  = 16'h0100;
  localparam int CR_CLR = 0;
  localparam int CR_FRZ = 1;
  localparam int CR_COR = 2;
  function automatic int cnt_idx(input int p, input int e, input int cnt_pp);
    return p * cnt_pp + e;
  endfunction
endpackage

// File: rtl/pstats_counter.sv
// pstats_counter: one event counter with wrap/saturate, clear, clear-on-read and sticky overflow
module pstats_counter #(
  parameter int g_width    = 16,
  parameter bit g_saturate = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               ev,
  input  logic               clr,
  input  logic               frz,
  input  logic               rd_clr,
  input  logic               ovf_clr,
  output logic [g_width-1:0] cnt,
  output logic               ovf
);
  logic               inc;
  logic               at_max;
  logic               ovf_set;
  logic [g_width-1:0] cnt_nxt;
  assign inc     = ev & ~frz;
  assign at_max  = &cnt;
  assign ovf_set = inc & at_max & ~rd_clr;
  // a clear-on-read keeps a same-cycle event by restarting at 1
  always_comb
    cnt_nxt = clr    ? '0 :
              rd_clr ? g_width'(inc) :
              !inc   ? cnt :
              at_max ? (g_saturate ? cnt : '0) :
                       cnt + g_width'(1);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      ovf <= clr ? 1'b0 : ovf_set ? 1'b1 : ovf & ~ovf_clr;
    end
endmodule

// File: rtl/pstats_cnt_bank.sv
// pstats_cnt_bank: per-port event counter bank behind a pipelined Wishbone slave
module pstats_cnt_bank
  import pstats_pkg::*;
#(
  parameter int g_nports    = 2,
  parameter int g_cnt_pp    = 16,
  parameter int g_cnt_width = 16,
  parameter int g_saturate  = 0
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [g_nports*g_cnt_pp-1:0] events_i,
  input  logic [15:0]                  wb_adr_i,
  input  logic [31:0]                  wb_dat_i,
  output logic [31:0]                  wb_dat_o,
  input  logic                         wb_cyc_i,
  input  logic                         wb_stb_i,
  input  logic                         wb_we_i,
  input  logic [3:0]                   wb_sel_i,
  output logic                         wb_ack_o,
  output logic                         wb_stall_o
);
  localparam int N  = g_nports * g_cnt_pp;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  localparam int PW = g_nports > 1 ? $clog2(g_nports) : 1;
  localparam logic [31:0] INFO = {9'b0, 1'(g_saturate != 0), 6'(g_cnt_width),
                                  8'(g_cnt_pp), 8'(g_nports)};
  logic        req, wr, rd, clr, frz, cor, cnt_hit, ovf_hit;
  logic [15:0] cidx, pidx;
  logic [31:0] rd_data;
  logic [N-1:0] ovf;
  logic [31:0] cnt_w [2**CW];
  logic [31:0] ovf_w [2**PW];
  logic        unused;
  assign req        = wb_cyc_i & wb_stb_i;
  assign wr         = req & wb_we_i;
  assign rd         = req & ~wb_we_i;
  assign cidx       = wb_adr_i - ADR_CNT;
  assign pidx       = wb_adr_i - ADR_OVF;
  assign cnt_hit    = wb_adr_i >= ADR_CNT && cidx < 16'(N);
  assign ovf_hit    = wb_adr_i >= ADR_OVF && pidx < 16'(g_nports);
  assign clr        = wr && wb_adr_i == ADR_CR && wb_dat_i[CR_CLR];
  assign wb_stall_o = 1'b0;
  assign unused     = ^{wb_sel_i, wb_dat_i, cidx, pidx};
  for (genvar p = 0; p < g_nports; p++) begin : g_port
    for (genvar e = 0; e < g_cnt_pp; e++) begin : g_ev
      localparam int I = cnt_idx(p, e, g_cnt_pp);
      logic [g_cnt_width-1:0] cnt_v;
      pstats_counter #(
        .g_width   (g_cnt_width),
        .g_saturate(g_saturate != 0)
      ) u_cnt (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .ev     (events_i[I]),
        .clr    (clr),
        .frz    (frz),
        .rd_clr (rd & cor & cnt_hit & (cidx == 16'(I))),
        .ovf_clr(wr & ovf_hit & (pidx == 16'(p)) & wb_dat_i[e]),
        .cnt    (cnt_v),
        .ovf    (ovf[I])
      );
      assign cnt_w[I] = 32'(cnt_v);
    end
    assign ovf_w[p] = 32'(ovf[p*g_cnt_pp +: g_cnt_pp]);
  end
  // pad the read muxes to a power of two so the index needs no range guard
  for (genvar i = N; i < 2**CW; i++) begin : g_cpad
    assign cnt_w[i] = '0;
  end
  for (genvar i = g_nports; i < 2**PW; i++) begin : g_ppad
    assign ovf_w[i] = '0;
  end
  always_comb
    rd_data = wb_adr_i == ADR_CR   ? {29'b0, cor, frz, 1'b0} :
              wb_adr_i == ADR_INFO ? INFO :
              ovf_hit              ? ovf_w[pidx[PW-1:0]] :
              cnt_hit              ? cnt_w[cidx[CW-1:0]] :
                                     '0;
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      frz      <= 1'b0;
      cor      <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      if (rd) wb_dat_o <= rd_data;
      if (wr && wb_adr_i == ADR_CR) begin
        frz <= wb_dat_i[CR_FRZ];
        cor <= wb_dat_i[CR_COR];
      end
    end
endmodule

// File: tb/tb_pstats_cnt_bank.sv
// tb_pstats_cnt_bank: wrap and saturate instances side by side against a behavioural model
module tb_pstats_cnt_bank;
  logic        clk = 0, rst_n = 0, cyc = 0, stb = 0, we = 0;
  logic [31:0] events = 0, wdat = 0;
  logic [15:0] adr = 0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat0, dat1;
  logic        ack0, ack1, stall0, stall1;
  int checks = 0, errors = 0;
  int          m_cnt [2][32];
  bit          m_ovf [2][32];
  bit          m_frz = 0, m_cor = 0, exp_ack = 0, exp_rd = 0;
  logic [31:0] exp_dat [2];
  logic [31:0] r0, r1;

  always #5 clk = ~clk;

  pstats_cnt_bank #(.g_nports(2), .g_cnt_pp(16), .g_cnt_width(4), .g_saturate(0)) u_wrap (
    .clk_i(clk), .rst_n_i(rst_n), .events_i(events), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat0), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_ack_o(ack0), .wb_stall_o(stall0));
  pstats_cnt_bank #(.g_nports(2), .g_cnt_pp(16), .g_cnt_width(4), .g_saturate(1)) u_sat (
    .clk_i(clk), .rst_n_i(rst_n), .events_i(events), .wb_adr_i(adr), .wb_dat_i(wdat),
    .wb_dat_o(dat1), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel),
    .wb_ack_o(ack1), .wb_stall_o(stall1));

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] m_read(int s, logic [15:0] a);
    logic [31:0] r;
    r = 0;
    if (a == 0) r = {29'b0, m_cor, m_frz, 1'b0};
    else if (a == 1) r = 32'h00041002 | (32'(s) << 22);
    else if (a == 2 || a == 3) for (int e = 0; e < 16; e++) r[e] = m_ovf[s][(int'(a) - 2) * 16 + e];
    else if (a >= 16'h100 && a < 16'h120) r = 32'(m_cnt[s][int'(a) - 256]);
    return r;
  endfunction

  // model: updated on each clock edge from the inputs that edge samples
  initial forever begin
    bit req, clr, hit, cor_rd;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) begin m_cnt[s][i] = 0; m_ovf[s][i] = 0; end
      m_frz = 0; m_cor = 0; exp_ack = 0; exp_rd = 0; exp_dat[0] = 0; exp_dat[1] = 0;
    end else begin
      req = cyc & stb;
      exp_ack = req;
      exp_rd = req & !we;
      if (exp_rd) for (int s = 0; s < 2; s++) exp_dat[s] = m_read(s, adr);
      clr = req && we && adr == 0 && wdat[0];
      for (int s = 0; s < 2; s++) for (int i = 0; i < 32; i++) begin
        if (clr) begin m_cnt[s][i] = 0; m_ovf[s][i] = 0; end
        else begin
          hit = events[i] && !m_frz;
          cor_rd = req && !we && m_cor && adr == 16'(256 + i);
          if (req && we && adr == 16'(2 + i / 16) && wdat[i % 16]) m_ovf[s][i] = 0;
          if (cor_rd) m_cnt[s][i] = hit ? 1 : 0;
          else if (hit) begin
            if (m_cnt[s][i] == 15) begin m_ovf[s][i] = 1; m_cnt[s][i] = s ? 15 : 0; end
            else m_cnt[s][i]++;
          end
        end
      end
      if (req && we && adr == 0) begin m_frz = wdat[1]; m_cor = wdat[2]; end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("stall_wrap", 32'(stall0), 32'(0));
    chk("stall_sat", 32'(stall1), 32'(0));
    chk("ack_wrap", 32'(ack0), 32'(exp_ack));
    chk("ack_sat", 32'(ack1), 32'(exp_ack));
    if (exp_ack && exp_rd) begin
      chk("dat_wrap", dat0, exp_dat[0]);
      chk("dat_sat", dat1, exp_dat[1]);
    end
    if (!rst_n) begin
      chk("rst_dat_wrap", dat0, 32'(0));
      chk("rst_dat_sat", dat1, 32'(0));
    end
  end

  task automatic xfer(input bit w, input logic [15:0] a, input logic [31:0] wd,
                      input logic [31:0] ev, output logic [31:0] d0, output logic [31:0] d1);
    int n;
    @(negedge clk);
    cyc = 1; stb = 1; we = w; adr = a; wdat = wd; events = ev;
    @(negedge clk);
    cyc = 0; stb = 0; we = 0; events = 0;
    n = 0;
    while (!ack0 && n < 4) begin @(negedge clk); n++; end
    if (!ack0) begin
      checks++; errors++;
      $display("FAIL xfer_timeout: no ack for adr 0x%04h, expected one", a);
    end
    d0 = dat0; d1 = dat1;
  endtask

  task automatic pulse(input int idx, input int n);
    @(negedge clk);
    events = 32'(1) << idx;
    repeat (n) @(negedge clk);
    events = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1;
    xfer(0, 16'h000, 0, 0, r0, r1); chk("cr_after_reset", r0, 32'h0);
    xfer(0, 16'h113, 0, 0, r0, r1); chk("cnt13_after_reset", r0, 32'h0);
    pulse(19, 5);
    xfer(0, 16'h113, 0, 0, r0, r1); chk("cnt_1_3", r0, 32'h5); chk("cnt_1_3_sat", r1, 32'h5);
    pulse(0, 17);
    xfer(0, 16'h100, 0, 0, r0, r1); chk("wrap_17", r0, 32'h1); chk("sat_17", r1, 32'hF);
    xfer(0, 16'h002, 0, 0, r0, r1); chk("ovf_wrap", r0, 32'h1); chk("ovf_sat", r1, 32'h1);
    xfer(1, 16'h002, 1, 0, r0, r1);
    xfer(0, 16'h002, 0, 0, r0, r1); chk("ovf_clr_wrap", r0, 32'h0); chk("ovf_clr_sat", r1, 32'h0);
    xfer(1, 16'h002, 1, 1, r0, r1);
    xfer(0, 16'h002, 0, 0, r0, r1); chk("set_wins_wrap", r0, 32'h0); chk("set_wins_sat", r1, 32'h1);
    xfer(1, 16'h000, 1, 0, r0, r1);
    pulse(2, 7);
    xfer(1, 16'h000, 4, 0, r0, r1);
    xfer(0, 16'h102, 0, 32'h4, r0, r1); chk("cor_old", r0, 32'h7);
    xfer(0, 16'h102, 0, 0, r0, r1); chk("cor_reread", r0, 32'h1);
    xfer(0, 16'h102, 0, 0, r0, r1); chk("cor_cleared", r0, 32'h0);
    xfer(0, 16'h000, 0, 0, r0, r1); chk("cr_cor", r0, 32'h4);
    xfer(1, 16'h000, 0, 0, r0, r1);
    pulse(16, 3);
    xfer(1, 16'h000, 2, 0, r0, r1);
    pulse(16, 10);
    xfer(0, 16'h110, 0, 0, r0, r1); chk("frz_hold", r0, 32'h3);
    xfer(0, 16'h000, 0, 0, r0, r1); chk("cr_frz", r0, 32'h2);
    xfer(1, 16'h000, 1, 32'hFFFF_FFFF, r0, r1);
    xfer(0, 16'h110, 0, 0, r0, r1); chk("clr_110", r0, 32'h0);
    xfer(0, 16'h113, 0, 0, r0, r1); chk("clr_113", r0, 32'h0);
    xfer(0, 16'h11F, 0, 0, r0, r1); chk("clr_11f", r1, 32'h0);
    pulse(0, 3);
    xfer(1, 16'h100, 9, 0, r0, r1);
    xfer(1, 16'h050, 32'hFFFF_FFFF, 0, r0, r1);
    xfer(1, 16'h001, 0, 0, r0, r1);
    xfer(0, 16'h050, 0, 0, r0, r1); chk("unmapped", r0, 32'h0);
    xfer(0, 16'h001, 0, 0, r0, r1); chk("info_wrap", r0, 32'h0004_1002); chk("info_sat", r1, 32'h0044_1002);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 16'h001;
    @(negedge clk); adr = 16'h0FF;  chk("b2b_ack0", 32'(ack0), 1); chk("b2b_info", dat0, 32'h0004_1002);
    @(negedge clk); adr = 16'h100;  chk("b2b_ack1", 32'(ack0), 1); chk("b2b_ff", dat0, 32'h0);
    @(negedge clk); cyc = 0; stb = 0; chk("b2b_ack2", 32'(ack0), 1); chk("b2b_cnt", dat1, 32'h3);
    @(negedge clk); chk("b2b_idle", 32'(ack0), 0);
    xfer(1, 16'h000, 6, 0, r0, r1);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = 16'h100;
    #2 rst_n = 0;
    @(negedge clk); cyc = 0; stb = 0;
    chk("rst_no_ack", 32'(ack0), 0); chk("rst_dat", dat0, 32'h0);
    @(negedge clk); rst_n = 1;
    xfer(0, 16'h000, 0, 0, r0, r1); chk("rst_cr", r0, 32'h0);
    xfer(0, 16'h100, 0, 0, r0, r1); chk("rst_cnt", r1, 32'h0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
